// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle request/acknowledge crossing pair.
// Used by the transmit end and its 3-flop level synchronizer.
package cdc_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   localparam int          SYNC_STAGES = 3;
   localparam logic [15:0] TO_CYC_DEF  = 16'd4096;

endpackage : cdc_pkg

// File: rtl/cdc_hs_tx_if.sv
// Handshake, crossing and status bundle of the transmit end; slave is the block side.
// Latency/backpressure live in the block: in_ready drops for the whole request/ack round trip.
interface cdc_hs_tx_if #(
   parameter int DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          tx_req;
   logic [DW-1:0] tx_data;
   logic          ack_in;
   logic          done;
   logic          busy;
   logic          to_err;
   logic          err_clr;

   modport master (
      output in_valid, in_data, ack_in, err_clr,
      input  in_ready, tx_req, tx_data, done, busy, to_err
   );

   modport slave (
      input  in_valid, in_data, ack_in, err_clr,
      output in_ready, tx_req, tx_data, done, busy, to_err
   );
endinterface : cdc_hs_tx_if

// File: rtl/cdc_sync3r.sv
// Resettable multi-flop level synchronizer; q follows d after SYNC_STAGES edges.
// No backpressure: a pure level pipeline.
module cdc_sync3r
   import cdc_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      end
   end

   assign q = r_sync[SYNC_STAGES-1];

endmodule : cdc_sync3r

// File: rtl/cdc_hs_tx.sv
// Transmit end of a two-phase toggle CDC: launches one word, then waits for the ack phase to match.
// Latency: tx_req/tx_data one edge after accept; done three edges after ack first sampled; in_ready low while waiting.
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int              DW     = 32,
   parameter int              TO_W   = 16,
   parameter logic [TO_W-1:0] TO_CYC = TO_W'(TO_CYC_DEF)
) (
   input  logic        clk,
   input  logic        rstn,
   cdc_hs_tx_if.slave  bus
);

   localparam logic [TO_W-1:0] L_TO_LAST = TO_W'(TO_CYC - 1'b1);

   state_t          r_state,   w_nxt_state;
   logic            r_tx_req,  w_nxt_req;
   logic [DW-1:0]   r_tx_data, w_nxt_data;
   logic [TO_W-1:0] r_cnt,     w_nxt_cnt;
   logic            r_done,    w_nxt_done;
   logic            r_to_err,  w_nxt_err;
   logic            w_ack_s3;

   cdc_sync3r u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (bus.ack_in),
      .q    (w_ack_s3)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_req   = r_tx_req;
      w_nxt_data  = r_tx_data;
      w_nxt_cnt   = r_cnt;
      w_nxt_done  = 1'b0;
      w_nxt_err   = r_to_err & ~bus.err_clr;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_nxt_data  = bus.in_data;
               w_nxt_req   = ~r_tx_req;
               w_nxt_cnt   = '0;
               w_nxt_state = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // Phase equality, not an edge: stable ack cycles after completion are harmless.
            if (w_ack_s3 == r_tx_req) begin
               w_nxt_state = IDLE;
               w_nxt_done  = 1'b1;
               w_nxt_cnt   = '0;
            end else begin
               if (r_cnt != '1) begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
               // Flag only; a late ack still completes the transfer normally.
               if (r_cnt == L_TO_LAST) begin
                  w_nxt_err = 1'b1;
               end
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_tx_req  <= 1'b0;
         r_tx_data <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_to_err  <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_tx_req  <= w_nxt_req;
         r_tx_data <= w_nxt_data;
         r_cnt     <= w_nxt_cnt;
         r_done    <= w_nxt_done;
         r_to_err  <= w_nxt_err;
      end
   end

   assign bus.in_ready = (r_state == IDLE);
   assign bus.busy     = (r_state == WAIT_ACK);
   assign bus.tx_req   = r_tx_req;
   assign bus.tx_data  = r_tx_data;
   assign bus.done     = r_done;
   assign bus.to_err   = r_to_err;

endmodule : cdc_hs_tx
